// File: rtl/i2s_audio_transmitter_pkg.sv
// Shared I2S framing constants and the slot-to-word-select mapping used by
// the transmitter (and future I2S master blocks).
package i2s_pkg;

   localparam int slot_bits  = 32;
   localparam int frame_bits = 64;
   localparam int w_slot_cnt = 6;

   // WS leads each channel by one bit: high for slots 31..62.
   function automatic logic ws_of_slot(input logic [w_slot_cnt-1:0] n);
      return (n >= w_slot_cnt'(31)) && (n <= w_slot_cnt'(62));
   endfunction

endpackage

// File: rtl/i2s_audio_transmitter_sck_gen.sv
// I2S bit-clock divider: SCK toggles every sck_half clk cycles and a one-clk
// strobe marks the cycle whose edge takes SCK from 1 to 0.
module i2s_sck_gen #(
   parameter int sck_half = 8
) (
   input  logic clk,
   input  logic reset,
   output logic sck,
   output logic sck_fall
);

   localparam int cnt_w = (sck_half > 1) ? $clog2(sck_half) : 1;
   localparam logic [cnt_w-1:0] half_last = cnt_w'(sck_half - 1);

   logic [cnt_w-1:0] half_cnt_q, half_cnt_d;
   logic             sck_q, sck_d;

   // sck_fall is asserted in the cycle before SCK drops, so registered bus
   // outputs enabled by it change on the same clk edge as SCK.
   always_comb begin
      half_cnt_d = half_cnt_q + cnt_w'(1);
      sck_d      = sck_q;
      sck_fall   = 1'b0;
      if (half_cnt_q == half_last) begin
         half_cnt_d = '0;
         sck_d      = ~sck_q;
         sck_fall   = sck_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         half_cnt_q <= '0;
         sck_q      <= 1'b0;
      end else begin
         half_cnt_q <= half_cnt_d;
         sck_q      <= sck_d;
      end
   end

   assign sck = sck_q;

endmodule

// File: rtl/i2s_audio_transmitter.sv
// I2S master transmitter: stereo sample pairs enter through a one-pair
// holding buffer and are shifted out MSB first; on underrun the last pair repeats.
module i2s_audio_transmitter
   import i2s_pkg::*;
#(
   parameter int clk_mhz  = 50,
   parameter int w_sample = 16,
   parameter int sck_half = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [w_sample-1:0] in_left,
   input  logic [w_sample-1:0] in_right,
   output logic                sck,
   output logic                ws,
   output logic                sd,
   output logic                frame_start,
   output logic                underrun
);

   if (w_sample < 1 || w_sample > slot_bits || sck_half < 2 || clk_mhz < 1) begin : g_bad_cfg
      $error("i2s_audio_transmitter: illegal parameter combination");
   end

   logic                  sck_fall;
   logic                  load;
   logic                  xfer;
   logic [w_slot_cnt-1:0] n_q, n_d;
   logic                  ws_q, ws_d;
   logic [frame_bits-1:0] shift_q, shift_d;
   logic                  full_q, full_d;
   logic [w_sample-1:0]   buf_l_q, buf_l_d, buf_r_q, buf_r_d;
   logic [w_sample-1:0]   last_l_q, last_l_d, last_r_q, last_r_d;
   logic                  frame_start_q, frame_start_d;
   logic                  underrun_q, underrun_d;
   logic [w_sample-1:0]   src_l, src_r;
   logic [frame_bits-1:0] frame_w;

   i2s_sck_gen #(.sck_half(sck_half)) u_sck_gen (
      .clk     (clk),
      .reset   (reset),
      .sck     (sck),
      .sck_fall(sck_fall)
   );

   // Valid/ready: a pair moves when in_valid and in_ready are both high on a
   // rising clk edge; upstream holds the pair stable while in_ready is low.
   assign xfer = in_valid & ~full_q;
   assign load = sck_fall & (n_q == '1);

   always_comb begin
      n_d           = n_q;
      ws_d          = ws_q;
      shift_d       = shift_q;
      full_d        = full_q;
      buf_l_d       = buf_l_q;
      buf_r_d       = buf_r_q;
      last_l_d      = last_l_q;
      last_r_d      = last_r_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      src_l         = full_q ? buf_l_q : last_l_q;
      src_r         = full_q ? buf_r_q : last_r_q;
      frame_w       = '0;
      frame_w[frame_bits-1 -: w_sample] = src_l;
      frame_w[slot_bits-1 -: w_sample]  = src_r;
      if (sck_fall) begin
         n_d  = n_q + w_slot_cnt'(1);
         ws_d = ws_of_slot(n_d);
         if (load) begin
            shift_d       = frame_w;
            last_l_d      = src_l;
            last_r_d      = src_r;
            full_d        = 1'b0;
            frame_start_d = 1'b1;
            underrun_d    = ~full_q;
         end else begin
            shift_d = {shift_q[frame_bits-2:0], 1'b0};
         end
      end
      // A capture in the load cycle wins over the clear so no pair is dropped.
      if (xfer) begin
         buf_l_d = in_left;
         buf_r_d = in_right;
         full_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_q           <= '1;
         ws_q          <= 1'b0;
         shift_q       <= '0;
         full_q        <= 1'b0;
         buf_l_q       <= '0;
         buf_r_q       <= '0;
         last_l_q      <= '0;
         last_r_q      <= '0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         n_q           <= n_d;
         ws_q          <= ws_d;
         shift_q       <= shift_d;
         full_q        <= full_d;
         buf_l_q       <= buf_l_d;
         buf_r_q       <= buf_r_d;
         last_l_q      <= last_l_d;
         last_r_q      <= last_r_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign in_ready    = ~full_q;
   assign ws          = ws_q;
   assign sd          = shift_q[frame_bits-1];
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_audio_transmitter.sv
// Directed bench for i2s_audio_transmitter: default instance plus a
// sck_half=2 / w_sample=24 instance, each decoded by an I2S receiver model.
module tb_i2s_audio_transmitter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          n_tests = 0;
   int          n_failed = 0;

   logic        in_valid_a = 1'b0, in_ready_a;
   logic [15:0] in_left_a = '0, in_right_a = '0;
   logic        sck_a, ws_a, sd_a, fs_a, ur_a;

   logic        in_valid_b = 1'b0, in_ready_b;
   logic [23:0] in_left_b = '0, in_right_b = '0;
   logic        sck_b, ws_b, sd_b, fs_b, ur_b;

   always #5 clk = ~clk;

   i2s_audio_transmitter dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_left(in_left_a), .in_right(in_right_a), .sck(sck_a), .ws(ws_a),
      .sd(sd_a), .frame_start(fs_a), .underrun(ur_a)
   );

   i2s_audio_transmitter #(.clk_mhz(50), .w_sample(24), .sck_half(2)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_left(in_left_b), .in_right(in_right_b), .sck(sck_b), .ws(ws_b),
      .sd(sd_b), .frame_start(fs_b), .underrun(ur_b)
   );

   // I2S receiver models: sample on SCK rise; a WS change marks the next bit
   // as the MSB of a new 32-bit slot of the channel WS now selects.
   logic [31:0] rx_sr_a = '0, rx_sr_b = '0;
   int          rx_cnt_a = 99, rx_cnt_b = 99;
   logic        rx_ws_a = 1'b0, rx_ws_b = 1'b0, rx_ch_a = 1'b0, rx_ch_b = 1'b0;
   logic [31:0] rx_l_a[$], rx_r_a[$], rx_l_b[$], rx_r_b[$];

   always @(posedge sck_a) begin
      rx_sr_a = {rx_sr_a[30:0], sd_a};
      if (rx_cnt_a == 31) begin
         if (rx_ch_a) rx_r_a.push_back(rx_sr_a);
         else rx_l_a.push_back(rx_sr_a);
      end
      rx_cnt_a++;
      if (ws_a != rx_ws_a) begin
         rx_cnt_a = 0;
         rx_ch_a  = ws_a;
      end
      rx_ws_a = ws_a;
   end

   always @(posedge sck_b) begin
      rx_sr_b = {rx_sr_b[30:0], sd_b};
      if (rx_cnt_b == 31) begin
         if (rx_ch_b) rx_r_b.push_back(rx_sr_b);
         else rx_l_b.push_back(rx_sr_b);
      end
      rx_cnt_b++;
      if (ws_b != rx_ws_b) begin
         rx_cnt_b = 0;
         rx_ch_b  = ws_b;
      end
      rx_ws_b = ws_b;
   end

   task automatic wait_fs_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (fs_a) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_fs_b(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (fs_b) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int first_sck = 0, first_ur = 0, first_fs = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (sck_a !== 1'b0) begin n_failed++; $display("FAIL reset_sck: got %b want 0", sck_a); end
      n_tests++; if (ws_a !== 1'b0) begin n_failed++; $display("FAIL reset_ws: got %b want 0", ws_a); end
      n_tests++; if (sd_a !== 1'b0) begin n_failed++; $display("FAIL reset_sd: got %b want 0", sd_a); end
      n_tests++; if (in_ready_a !== 1'b1) begin n_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
      n_tests++; if (fs_a !== 1'b0) begin n_failed++; $display("FAIL reset_frame_start: got %b want 0", fs_a); end
      n_tests++; if (ur_a !== 1'b0) begin n_failed++; $display("FAIL reset_underrun: got %b want 0", ur_a); end
      reset = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (sck_a && first_sck == 0) first_sck = i;
         if (fs_a && first_fs == 0) first_fs = i;
         if (ur_a && first_ur == 0) first_ur = i;
         if (first_ur != 0) break;
      end
      n_tests++; if (first_sck != 8) begin n_failed++; $display("FAIL first_sck_rise: got %0d want 8", first_sck); end
      n_tests++; if (first_fs != 16) begin n_failed++; $display("FAIL first_frame_start: got %0d want 16", first_fs); end
      n_tests++; if (first_ur != 16) begin n_failed++; $display("FAIL first_underrun: got %0d want 16", first_ur); end
   endtask

   task automatic test_idle();
      int ur_cnt = 0, first_ur = 0, ur_bad = 0, fs_cnt = 0, sd_hi = 0;
      int ws_hi = 0, ws_rise = 0, ws_fall = 0;
      logic prev_ws;
      prev_ws = ws_a;
      for (int t = 1; t <= 3072; t++) begin
         @(negedge clk);
         if (ur_a) begin
            ur_cnt++;
            if (first_ur == 0) first_ur = t;
            if (t % 1024 != 0) ur_bad++;
         end
         if (fs_a) fs_cnt++;
         if (sd_a) sd_hi++;
         if (t <= 1024 && ws_a) ws_hi++;
         if (ws_a && !prev_ws && ws_rise == 0) ws_rise = t;
         if (!ws_a && prev_ws && ws_fall == 0) ws_fall = t;
         prev_ws = ws_a;
      end
      n_tests++; if (ur_cnt != 3 || ur_bad != 0) begin n_failed++; $display("FAIL idle_underrun_count: got %0d (%0d off-period) want 3", ur_cnt, ur_bad); end
      n_tests++; if (first_ur != 1024) begin n_failed++; $display("FAIL idle_underrun_period: got %0d want 1024", first_ur); end
      n_tests++; if (fs_cnt != 3) begin n_failed++; $display("FAIL idle_frame_start_count: got %0d want 3", fs_cnt); end
      n_tests++; if (sd_hi != 0) begin n_failed++; $display("FAIL idle_sd_zero: got %0d high cycles want 0", sd_hi); end
      n_tests++; if (ws_hi != 512) begin n_failed++; $display("FAIL idle_ws_high: got %0d want 512", ws_hi); end
      n_tests++; if (ws_rise != 496) begin n_failed++; $display("FAIL idle_ws_rise: got %0d want 496", ws_rise); end
      n_tests++; if (ws_fall != 1008) begin n_failed++; $display("FAIL idle_ws_fall: got %0d want 1008", ws_fall); end
   endtask

   task automatic test_single_pair();
      bit ok;
      logic [31:0] exp_l[$], exp_r[$];
      in_valid_a = 1'b1; in_left_a = 16'hA5C3; in_right_a = 16'h8001;
      @(negedge clk);
      n_tests++; if (in_ready_a !== 1'b0) begin n_failed++; $display("FAIL single_captured: in_ready got %b want 0", in_ready_a); end
      in_valid_a = 1'b0; in_left_a = '0; in_right_a = '0;
      wait_fs_a(ok);
      n_tests++; if (!ok) begin n_failed++; $display("FAIL single_load_timeout: got no frame_start want one"); end
      n_tests++; if (ur_a !== 1'b0) begin n_failed++; $display("FAIL single_no_underrun: got %b want 0", ur_a); end
      n_tests++; if (sd_a !== 1'b1) begin n_failed++; $display("FAIL single_msb_at_load: got %b want 1", sd_a); end
      rx_l_a.delete(); rx_r_a.delete();
      wait_fs_a(ok);
      n_tests++; if (!ok || ur_a !== 1'b1) begin n_failed++; $display("FAIL single_repeat_underrun: got %b want 1", ur_a); end
      wait_fs_a(ok);
      n_tests++; if (!ok) begin n_failed++; $display("FAIL single_third_frame_timeout: got no frame_start want one"); end
      exp_l = '{32'hA5C3_0000, 32'hA5C3_0000};
      exp_r = '{32'h8001_0000, 32'h8001_0000};
      n_tests++; if (rx_l_a.size() != 2 || rx_r_a.size() != 2) begin n_failed++; $display("FAIL single_word_count: got %0d/%0d want 2/2", rx_l_a.size(), rx_r_a.size()); end
      for (int i = 0; i < 2; i++) begin
         n_tests++; if (i >= rx_l_a.size() || rx_l_a[i] !== exp_l[i]) begin n_failed++; $display("FAIL single_left[%0d]: got %h want %h", i, (i < rx_l_a.size()) ? rx_l_a[i] : 32'h0, exp_l[i]); end
         n_tests++; if (i >= rx_r_a.size() || rx_r_a[i] !== exp_r[i]) begin n_failed++; $display("FAIL single_right[%0d]: got %h want %h", i, (i < rx_r_a.size()) ? rx_r_a[i] : 32'h0, exp_r[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int k = 0, fs_seen = 0, xfers = 0, ur_seen = 0, rdy_bad = 0;
      bit pending = 1'b0;
      logic [31:0] exp_l[$], exp_r[$];
      rx_l_a.delete(); rx_r_a.delete();
      in_valid_a = 1'b1; in_left_a = 16'h1000; in_right_a = 16'h2000;
      for (int i = 0; i < 5000; i++) begin
         if (in_valid_a && in_ready_a) begin
            xfers++;
            pending = 1'b1;
         end
         if (i > 0 && in_ready_a && !fs_a) rdy_bad++;
         if (i > 0 && fs_a) begin
            fs_seen++;
            if (ur_a) ur_seen++;
         end
         if (fs_seen == 4) break;
         @(negedge clk);
         if (pending) begin
            k++;
            in_left_a  = 16'h1000 + 16'(k);
            in_right_a = 16'h2000 + 16'(k);
            pending    = 1'b0;
         end
      end
      @(negedge clk);
      in_valid_a = 1'b0;
      n_tests++; if (fs_seen != 4) begin n_failed++; $display("FAIL b2b_frames: got %0d want 4", fs_seen); end
      n_tests++; if (xfers != 5) begin n_failed++; $display("FAIL b2b_transfers: got %0d want 5", xfers); end
      n_tests++; if (ur_seen != 0) begin n_failed++; $display("FAIL b2b_underrun: got %0d want 0", ur_seen); end
      n_tests++; if (rdy_bad != 0) begin n_failed++; $display("FAIL b2b_ready_between_loads: got %0d cycles want 0", rdy_bad); end
      exp_l = '{32'hA5C3_0000, 32'h1000_0000, 32'h1001_0000, 32'h1002_0000};
      exp_r = '{32'h8001_0000, 32'h2000_0000, 32'h2001_0000, 32'h2002_0000};
      n_tests++; if (rx_l_a.size() != 4 || rx_r_a.size() != 4) begin n_failed++; $display("FAIL b2b_word_count: got %0d/%0d want 4/4", rx_l_a.size(), rx_r_a.size()); end
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (i >= rx_l_a.size() || rx_l_a[i] !== exp_l[i]) begin n_failed++; $display("FAIL b2b_left[%0d]: got %h want %h", i, (i < rx_l_a.size()) ? rx_l_a[i] : 32'h0, exp_l[i]); end
         n_tests++; if (i >= rx_r_a.size() || rx_r_a[i] !== exp_r[i]) begin n_failed++; $display("FAIL b2b_right[%0d]: got %h want %h", i, (i < rx_r_a.size()) ? rx_r_a[i] : 32'h0, exp_r[i]); end
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      logic [31:0] exp_l[$], exp_r[$];
      in_valid_a = 1'b1; in_left_a = 16'h5A5A; in_right_a = 16'hC3C3;
      n_tests++; if (in_ready_a !== 1'b0) begin n_failed++; $display("FAIL simul_full_before: in_ready got %b want 0", in_ready_a); end
      wait_fs_a(ok);
      n_tests++; if (!ok || ur_a !== 1'b0) begin n_failed++; $display("FAIL simul_load_old: underrun got %b want 0", ur_a); end
      n_tests++; if (!(in_valid_a && in_ready_a)) begin n_failed++; $display("FAIL simul_accept_in_load_clk: in_ready got %b want 1", in_ready_a); end
      rx_l_a.delete(); rx_r_a.delete();
      @(negedge clk);
      in_valid_a = 1'b0;
      n_tests++; if (in_ready_a !== 1'b0) begin n_failed++; $display("FAIL simul_full_after: in_ready got %b want 0", in_ready_a); end
      wait_fs_a(ok);
      n_tests++; if (!ok || ur_a !== 1'b0) begin n_failed++; $display("FAIL simul_new_pair_load: underrun got %b want 0", ur_a); end
      wait_fs_a(ok);
      n_tests++; if (!ok || ur_a !== 1'b1) begin n_failed++; $display("FAIL simul_repeat: underrun got %b want 1", ur_a); end
      exp_l = '{32'h1004_0000, 32'h5A5A_0000};
      exp_r = '{32'h2004_0000, 32'hC3C3_0000};
      n_tests++; if (rx_l_a.size() != 2 || rx_r_a.size() != 2) begin n_failed++; $display("FAIL simul_word_count: got %0d/%0d want 2/2", rx_l_a.size(), rx_r_a.size()); end
      for (int i = 0; i < 2; i++) begin
         n_tests++; if (i >= rx_l_a.size() || rx_l_a[i] !== exp_l[i]) begin n_failed++; $display("FAIL simul_left[%0d]: got %h want %h", i, (i < rx_l_a.size()) ? rx_l_a[i] : 32'h0, exp_l[i]); end
         n_tests++; if (i >= rx_r_a.size() || rx_r_a[i] !== exp_r[i]) begin n_failed++; $display("FAIL simul_right[%0d]: got %h want %h", i, (i < rx_r_a.size()) ? rx_r_a[i] : 32'h0, exp_r[i]); end
      end
   endtask

   task automatic test_mid_reset();
      int first_ur = 0, first_fs = 0, sd_hi = 0;
      in_valid_a = 1'b1; in_left_a = 16'hDEAD; in_right_a = 16'hBEEF;
      @(negedge clk);
      in_valid_a = 1'b0;
      n_tests++; if (in_ready_a !== 1'b0) begin n_failed++; $display("FAIL midrst_buffer_full: in_ready got %b want 0", in_ready_a); end
      repeat (319) @(negedge clk);
      reset = 1'b1;
      #1;
      n_tests++; if (sck_a !== 1'b0) begin n_failed++; $display("FAIL midrst_sck: got %b want 0", sck_a); end
      n_tests++; if (ws_a !== 1'b0) begin n_failed++; $display("FAIL midrst_ws: got %b want 0", ws_a); end
      n_tests++; if (sd_a !== 1'b0) begin n_failed++; $display("FAIL midrst_sd: got %b want 0", sd_a); end
      n_tests++; if (in_ready_a !== 1'b1) begin n_failed++; $display("FAIL midrst_in_ready: got %b want 1", in_ready_a); end
      n_tests++; if (fs_a !== 1'b0 || ur_a !== 1'b0) begin n_failed++; $display("FAIL midrst_pulses: got fs=%b ur=%b want 0/0", fs_a, ur_a); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge clk);
         if (ur_a && first_ur == 0) first_ur = i;
         if (fs_a && first_fs == 0) first_fs = i;
         if (sd_a) sd_hi++;
      end
      n_tests++; if (first_ur != 16) begin n_failed++; $display("FAIL midrst_underrun: got %0d want 16", first_ur); end
      n_tests++; if (first_fs != 16) begin n_failed++; $display("FAIL midrst_frame_start: got %0d want 16", first_fs); end
      n_tests++; if (sd_hi != 0) begin n_failed++; $display("FAIL midrst_zero_frame: got %0d sd high cycles want 0", sd_hi); end
   endtask

   task automatic test_sweep();
      bit ok;
      int r1 = 0, r2 = 0;
      logic pv;
      logic [31:0] exp_l[$], exp_r[$];
      wait_fs_b(ok);
      n_tests++; if (!ok) begin n_failed++; $display("FAIL sweep_sync_timeout: got no frame_start want one"); end
      in_valid_b = 1'b1; in_left_b = 24'h800000; in_right_b = 24'h7FFFFF;
      @(negedge clk);
      in_valid_b = 1'b0;
      n_tests++; if (in_ready_b !== 1'b0) begin n_failed++; $display("FAIL sweep_captured: in_ready got %b want 0", in_ready_b); end
      pv = sck_b;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (sck_b && !pv) begin
            if (r1 == 0) r1 = i;
            else if (r2 == 0) r2 = i;
         end
         pv = sck_b;
      end
      n_tests++; if (r1 == 0 || r2 - r1 != 4) begin n_failed++; $display("FAIL sweep_sck_period: got %0d want 4", r2 - r1); end
      wait_fs_b(ok);
      n_tests++; if (!ok || ur_b !== 1'b0 || sd_b !== 1'b1) begin n_failed++; $display("FAIL sweep_load: got ur=%b sd=%b want 0/1", ur_b, sd_b); end
      rx_l_b.delete(); rx_r_b.delete();
      wait_fs_b(ok);
      n_tests++; if (!ok || ur_b !== 1'b1) begin n_failed++; $display("FAIL sweep_repeat: underrun got %b want 1", ur_b); end
      wait_fs_b(ok);
      exp_l = '{32'h8000_0000, 32'h8000_0000};
      exp_r = '{32'h7FFF_FF00, 32'h7FFF_FF00};
      n_tests++; if (!ok || rx_l_b.size() != 2 || rx_r_b.size() != 2) begin n_failed++; $display("FAIL sweep_word_count: got %0d/%0d want 2/2", rx_l_b.size(), rx_r_b.size()); end
      for (int i = 0; i < 2; i++) begin
         n_tests++; if (i >= rx_l_b.size() || rx_l_b[i] !== exp_l[i]) begin n_failed++; $display("FAIL sweep_left[%0d]: got %h want %h", i, (i < rx_l_b.size()) ? rx_l_b[i] : 32'h0, exp_l[i]); end
         n_tests++; if (i >= rx_r_b.size() || rx_r_b[i] !== exp_r[i]) begin n_failed++; $display("FAIL sweep_right[%0d]: got %h want %h", i, (i < rx_r_b.size()) ? rx_r_b[i] : 32'h0, exp_r[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_pair();
      test_back_to_back();
      test_simultaneous();
      test_mid_reset();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
